// File: rtl/cmpi_share_arb.sv
// Shared comparator with round-robin arbitration over NUM_REQ requesters and a
// single-entry result register. Optional illegal-predicate tracking: CMPI_SHARE_ARB_ERR_EN.
module cmpi_share_arb #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]     req_pred,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic                     resp_result,
  output logic                     err_pred,
  output logic [2:0]               err_id,
  output logic                     dbg_hold
);

  // Handshake rule for both sides: a transfer happens in a cycle where valid
  // and ready are both high; valid and its payload hold until that cycle.
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t             state;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      win;
  logic [NUM_REQ-1:0] win_oh;
  logic               found;
  logic               grant_ok;
  logic               hs;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [3:0]         op_pred;
  logic               cmp_res;
  int                 idx;

  function automatic logic cmp_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [3:0] p);
    logic r;
    case (p)
      4'd0:    r = (a == b);
      4'd1:    r = (a != b);
      4'd2:    r = ($signed(a) <  $signed(b));
      4'd3:    r = ($signed(a) <= $signed(b));
      4'd4:    r = ($signed(a) >  $signed(b));
      4'd5:    r = ($signed(a) >= $signed(b));
      4'd6:    r = (a <  b);
      4'd7:    r = (a <= b);
      4'd8:    r = (a >  b);
      4'd9:    r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        win         = PW'(idx);
        win_oh[idx] = 1'b1;
      end
    end
  end

  // Only the owner's resp_ready can free the entry for a same-cycle refill.
  assign grant_ok  = rst_n && ((state == IDLE) || resp_ready[owner]);
  assign hs        = found && grant_ok;
  assign req_ready = hs ? win_oh : '0;

  assign op_a    = req_a[int'(win)*WIDTH +: WIDTH];
  assign op_b    = req_b[int'(win)*WIDTH +: WIDTH];
  assign op_pred = req_pred[int'(win)*4 +: 4];
  assign cmp_res = cmp_fn(op_a, op_b, op_pred);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      resp_valid  <= '0;
      resp_result <= 1'b0;
    end else if (hs) begin
      state       <= HOLD;
      owner       <= win;
      resp_valid  <= win_oh;
      resp_result <= cmp_res;
      ptr         <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    end else if ((state == HOLD) && resp_ready[owner]) begin
      state      <= IDLE;
      resp_valid <= '0;
    end
  end

  assign dbg_hold = (state == HOLD);

`ifdef CMPI_SHARE_ARB_ERR_EN
  // Sticky: only the first accepted illegal predicate is recorded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pred <= 1'b0;
      err_id   <= 3'd0;
    end else if (hs && (op_pred >= 4'd10) && !err_pred) begin
      err_pred <= 1'b1;
      err_id   <= 3'(win);
    end
  end
`else
  assign err_pred = 1'b0;
  assign err_id   = 3'd0;
`endif

endmodule

// File: tb/tb_cmpi_share_arb.sv
// Directed bench for cmpi_share_arb (WIDTH=8, NUM_REQ=4); honours CMPI_SHARE_ARB_ERR_EN.
module tb_cmpi_share_arb;

  localparam int W = 8;
  localparam int N = 4;
`ifdef CMPI_SHARE_ARB_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*4-1:0] req_pred;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic           resp_result;
  logic           err_pred;
  logic [2:0]     err_id;
  logic           dbg_hold;

  int checks   = 0;
  int failures = 0;
  logic exp_res [N];

  cmpi_share_arb #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_pred(req_pred),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .err_pred(err_pred), .err_id(err_id),
    .dbg_hold(dbg_hold)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] p);
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_pred[i*4 +: 4] = p;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; resp_ready = '0;
    req_a = '0; req_b = '0; req_pred = '0;
    step(); step();
    req_valid = 4'hF; settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_err_pred", err_pred, 0);
    chk("rst_err_id", err_id, 0);
    chk("rst_state", dbg_hold, 0);
    step();

    // Requester 2: 0xFF slt 0x01 (-1 < 1) -> 1
    rst_n = 1'b1; req_valid = 4'b0100; set_req(2, 8'hFF, 8'h01, 4'd2); settle();
    chk("r2_slt_ready", req_ready, 4'b0100);
    step();
    req_valid = '0; settle();
    chk("r2_slt_valid", resp_valid, 4'b0100);
    chk("r2_slt_result", resp_result, 1);
    chk("r2_slt_state", dbg_hold, 1);
    // Drain-and-refill: ugt 255 > 1 -> 1
    resp_ready = 4'b0100; req_valid = 4'b0100; set_req(2, 8'hFF, 8'h01, 4'd8); settle();
    chk("r2_ugt_ready", req_ready, 4'b0100);
    step();
    chk("r2_ugt_valid", resp_valid, 4'b0100);
    chk("r2_ugt_result", resp_result, 1);
    // ult 255 < 1 -> 0
    set_req(2, 8'hFF, 8'h01, 4'd6); settle();
    step();
    req_valid = '0; settle();
    chk("r2_ult_result", resp_result, 0);
    // Requester 3 (ptr now 3): sle -128 <= 127 -> 1
    req_valid = 4'b1000; set_req(3, 8'h80, 8'h7F, 4'd3); settle();
    chk("r3_sle_ready", req_ready, 4'b1000);
    step();
    req_valid = '0; settle();
    chk("r3_sle_result", resp_result, 1);
    resp_ready = 4'hF; step();
    chk("drain_valid", resp_valid, 0);
    chk("drain_state", dbg_hold, 0);

    // All valid, all ready: grants 0,1,2,3,0 and one response per cycle
    set_req(0, 8'h05, 8'h05, 4'd0); exp_res[0] = 1'b1;  // eq
    set_req(1, 8'h01, 8'hFF, 4'd4); exp_res[1] = 1'b1;  // sgt 1 > -1
    set_req(2, 8'h01, 8'hFF, 4'd9); exp_res[2] = 1'b0;  // uge 1 >= 255
    set_req(3, 8'h80, 8'h7F, 4'd7); exp_res[3] = 1'b0;  // ule 128 <= 127
    req_valid = 4'hF; resp_ready = 4'hF; settle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_ready_%0d", i), req_ready, 32'(1 << (i % N)));
      if (i > 0) begin
        chk($sformatf("rr_valid_%0d", i), resp_valid, 32'(1 << ((i - 1) % N)));
        chk($sformatf("rr_result_%0d", i), resp_result, 32'(exp_res[(i - 1) % N]));
      end
      step();
    end
    chk("rr_last_valid", resp_valid, 4'b0001);
    chk("rr_last_result", resp_result, 1);
    req_valid = '0; step();
    chk("rr_drain_valid", resp_valid, 0);

    // Back-pressure: requester 1 stalls 5 cycles while requester 3 waits
    req_valid = 4'b0010; resp_ready = '0; set_req(1, 8'hFF, 8'h01, 4'd2); settle();
    chk("bp_r1_ready", req_ready, 4'b0010);
    step();
    req_valid = 4'b1000; resp_ready = 4'b1101; settle();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_ready_%0d", i), req_ready, 0);
      chk($sformatf("bp_valid_%0d", i), resp_valid, 4'b0010);
      chk($sformatf("bp_result_%0d", i), resp_result, 1);
      step();
    end
    resp_ready = 4'b0010; settle();
    chk("bp_r3_ready", req_ready, 4'b1000);
    step();
    req_valid = '0; settle();
    chk("bp_r3_valid", resp_valid, 4'b1000);
    chk("bp_r3_result", resp_result, 0);

    // Reset while entry full for requester 0
    req_valid = 4'b0001; resp_ready = 4'hF; set_req(0, 8'h05, 8'h05, 4'd0); settle();
    chk("mr_r0_ready", req_ready, 4'b0001);
    step();
    chk("mr_r0_valid", resp_valid, 4'b0001);
    rst_n = 1'b0; req_valid = 4'b1010; resp_ready = '0; settle();
    chk("mr_rst_ready", req_ready, 0);
    step();
    chk("mr_rst_valid", resp_valid, 0);
    chk("mr_rst_result", resp_result, 0);
    rst_n = 1'b1; req_valid = 4'b1001; settle();
    chk("mr_ptr0_ready", req_ready, 4'b0001);
    req_valid = 4'b1010; settle();
    chk("mr_1010_ready", req_ready, 4'b0010);
    step();
    req_valid = '0; settle();
    chk("mr_1010_valid", resp_valid, 4'b0010);
    resp_ready = 4'hF; step();

    // Illegal predicates: requester 3 pred 12, then requester 0 pred 15
    set_req(3, 8'h00, 8'h00, 4'd12); req_valid = 4'b1000; settle();
    chk("ill_r3_ready", req_ready, 4'b1000);
    step();
    req_valid = 4'b0001; set_req(0, 8'h00, 8'h00, 4'd15); settle();
    chk("ill_r3_valid", resp_valid, 4'b1000);
    chk("ill_r3_result", resp_result, 0);
    chk("ill_r3_err_pred", err_pred, 32'(EXP_ERR));
    chk("ill_r3_err_id", err_id, EXP_ERR ? 3 : 0);
    chk("ill_r0_ready", req_ready, 4'b0001);
    step();
    req_valid = '0; settle();
    chk("ill_r0_valid", resp_valid, 4'b0001);
    chk("ill_r0_result", resp_result, 0);
    chk("ill_r0_err_pred", err_pred, 32'(EXP_ERR));
    chk("ill_r0_err_id", err_id, EXP_ERR ? 3 : 0);
    step(); step();
    chk("ill_hold_err_pred", err_pred, 32'(EXP_ERR));
    chk("ill_hold_err_id", err_id, EXP_ERR ? 3 : 0);
    chk("end_idle", resp_valid, 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
